codec_stream_buffer: RTL and testbench
======================================

# codec_stream_buffer

Stereo sample FIFO between the FIR filter outputs and the audio CODEC write port. It absorbs sample pairs produced on the CODEC_50 domain at arbitrary strobes and drains them exactly when the CODEC requests (write_ready). It prefills before draining, replays the last sample on starvation, and reports overflow and underflow so the filter path can be debugged on the board.

## Interface
- DATA_WIDTH, 24: bits per channel sample (signed, passed through untouched).
- ADDR_WIDTH, 3: FIFO depth DEPTH = 2^ADDR_WIDTH sample pairs.
- PREFILL, 4: occupancy required before draining starts; legal range 1..DEPTH.

- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  producer presents a sample pair this cycle.
- in_left  in  DATA_WIDTH  left sample.
- in_right  in  DATA_WIDTH  right sample.
- in_ready  out  1  FIFO can accept a pair this cycle.
- write_ready  in  1  CODEC can accept a pair this cycle.
- write  out  1  write strobe to CODEC.
- writedata_left  out  DATA_WIDTH  left sample to CODEC.
- writedata_right  out  DATA_WIDTH  right sample to CODEC.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a pair was dropped because FIFO was full.
- underflow_cnt  out  16  number of starved CODEC writes, saturating at 16'hFFFF.

## Operation
- Storage: DEPTH-entry memory of {left,right}, wr_ptr/rd_ptr of ADDR_WIDTH bits wrap modulo DEPTH; count register holds occupancy (not derived from pointers).
- Push: in_valid & in_ready writes mem[wr_ptr], wr_ptr+1. in_ready = (count != DEPTH), combinational from registered count.
- Full drop: in_valid while count == DEPTH -> pair discarded, overflow <= 1 (cleared only by reset). A pop in the same cycle does NOT make room for that push.
- write = write_ready & ~reset (CODEC is always served; never stalls the DAC).
- writedata_* = mem[rd_ptr] when state RUN and count != 0; otherwise last_reg (last pair actually sent; 0 after reset).
- Accept event = write & write_ready.
- State FILL: accept never pops; last_reg replayed; underflow_cnt unchanged. Go to RUN when count >= PREFILL (registered count, evaluated each cycle).
- State RUN: accept with count != 0 -> pop, rd_ptr+1, last_reg <= mem[rd_ptr]. Accept with count == 0 -> no pop, last_reg replayed, underflow_cnt+1 (saturating), next state FILL.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Push while empty in RUN, same cycle as accept: underflow (no bypass), push stored, count becomes 1, state FILL.
- Reset (any time, including mid-stream): pointers 0, count 0, last_reg 0, state FILL, overflow 0, underflow_cnt 0; memory contents need not be cleared.

## Timing
- All state updates on rising clk; outputs in_ready, write, writedata_* are combinational from registers plus write_ready.
- Reset outputs (cycle after reset asserted): in_ready 1, write 0 while reset high, writedata_* 0, count 0, overflow 0, underflow_cnt 0.
- Push-to-visibility: pushed pair appears at writedata_* at earliest the cycle after the push (RUN, FIFO was empty).
- FILL->RUN: the cycle after count reaches PREFILL, writedata_* switches from last_reg to FIFO head.
- count reflects a push/pop on the cycle after it occurs; overflow sets the cycle after the dropped push.
- Throughput: one push and one pop per cycle maximum.

## Test plan
- Reset then push 4 pairs (L=1..4, R=-1..-4) with write_ready low -> count=4, state RUN next cycle, writedata_left=1, in_ready=1, overflow=0.
- Prefill gate: push 3 pairs (PREFILL=4), pulse write_ready 5 times -> write pulses 5 times, writedata=0 each time, count stays 3, underflow_cnt=0.
- Drain/underflow: 4 pairs queued in RUN, write_ready held 6 cycles -> outputs 1,2,3,4 then 4 replayed, underflow_cnt=1 and state FILL after 5th accept, 6th accept replays 4 with underflow_cnt still 1.
- Overflow: push 9 pairs back-to-back, no draining -> count=8, in_ready=0 after 8th, 9th dropped, overflow=1, then one pop -> in_ready=1, head still pair 1 sent first.
- Wrap-around: stream 20 pairs with in_valid and write_ready each asserted every cycle after prefill -> output order exactly 1..20, count constant 4, underflow_cnt=0, overflow=0.
- Mid-stream reset with count=5 and overflow=1 -> next cycle count=0, overflow=0, underflow_cnt=0, writedata=0, write=0 while reset high.

Source files
------------

// File: rtl/codec_stream_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : codec_stream_buffer_if
//  Description : Bundle of the producer-side (FIR output) and CODEC-side
//                signals of the stereo sample FIFO, plus its status outputs.
//                  in_valid/in_left/in_right  : producer -> buffer
//                  in_ready                   : buffer -> producer
//                  write_ready                : CODEC  -> buffer
//                  write/writedata_left/right : buffer -> CODEC
//                  count/overflow/underflow_cnt : buffer status
//                master = producer/CODEC side, slave = the buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface codec_stream_buffer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_left;
    logic [DATA_WIDTH-1:0] in_right;
    logic                  in_ready;
    logic                  write_ready;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic [15:0]           underflow_cnt;

    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right,
        input  count, overflow, underflow_cnt
    );

    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right,
        output count, overflow, underflow_cnt
    );
endinterface
`default_nettype wire

// File: rtl/codec_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : codec_stream_buffer
//  Description : Stereo sample FIFO between the FIR filter outputs and the
//                audio CODEC write port. Prefills to PREFILL pairs before
//                draining, serves every CODEC request (replaying the last
//                pair sent when starved), and reports sticky overflow and a
//                saturating count of starved CODEC writes.
//  Ports       : clk   - system clock
//                reset - synchronous, active-high reset
//                bus   - codec_stream_buffer_if.slave (producer input,
//                        CODEC output, count/overflow/underflow_cnt status)
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_stream_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int PREFILL    = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    codec_stream_buffer_if.slave  bus
);
    localparam int                  c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(c_DEPTH_INT);
    localparam logic [ADDR_WIDTH:0] c_PREFILL   = (ADDR_WIDTH+1)'(PREFILL);
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [15:0]         c_UF_MAX    = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [2*DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [2*DATA_WIDTH-1:0] r_last;
    logic                    r_overflow;
    logic [15:0]             r_underflow_cnt;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_starve;
    logic [2*DATA_WIDTH-1:0] w_out;

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a concurrent push.
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.in_valid & ~w_full;
    assign w_drop   = bus.in_valid & w_full;

    // The DAC is never stalled: every CODEC request is answered.
    assign bus.write = bus.write_ready & ~reset;
    assign w_accept  = bus.write & bus.write_ready;

    // Head of FIFO only while draining with data; otherwise replay last pair.
    assign w_out = ((r_state == ST_RUN) && !w_empty) ? r_mem[r_rd_ptr] : r_last;

    assign bus.in_ready        = ~w_full;
    assign bus.writedata_left  = w_out[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.writedata_right = w_out[DATA_WIDTH-1:0];
    assign bus.count           = r_count;
    assign bus.overflow        = r_overflow;
    assign bus.underflow_cnt   = r_underflow_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_starve     = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (r_count >= c_PREFILL) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_empty) begin
                        // Starved: no bypass of a same-cycle push; refill first.
                        w_starve     = 1'b1;
                        w_state_next = ST_FILL;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
        endcase
    end

    // Sample storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_left, bus.in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_last          <= '0;
            r_overflow      <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_starve && (r_underflow_cnt != c_UF_MAX)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_codec_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_stream_buffer
//  Description : Directed self-checking bench for codec_stream_buffer
//                (DATA_WIDTH=24, ADDR_WIDTH=3, PREFILL=4). Inputs change
//                1 ns after the rising edge; outputs are sampled 1 ns later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_stream_buffer;
    localparam int c_DW = 24;
    localparam int c_AW = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    codec_stream_buffer_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

    codec_stream_buffer #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .PREFILL    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    int c_drain_l   [6] = '{1, 2, 3, 4, 4, 4};
    int c_drain_uf  [6] = '{0, 0, 0, 0, 1, 1};
    int c_drain_cnt [6] = '{3, 2, 1, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] s24(input int v);
        logic [23:0] t;
        t   = 24'(v);
        s24 = {8'h00, t};
    endfunction

    task automatic apply(input logic v, input int l, input int r, input logic wr);
        bus.in_valid    = v;
        bus.in_left     = 24'(l);
        bus.in_right    = 24'(r);
        bus.write_ready = wr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(1'b0, 0, 0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset state (write_ready high must not strobe)
        reset = 1'b1;
        apply(1'b0, 0, 0, 1'b1);
        tick();
        tick();
        chk("rst_write",    32'(bus.write),           32'd0);
        chk("rst_in_ready", 32'(bus.in_ready),        32'd1);
        chk("rst_wd_left",  32'(bus.writedata_left),  32'd0);
        chk("rst_wd_right", 32'(bus.writedata_right), 32'd0);
        chk("rst_count",    32'(bus.count),           32'd0);
        chk("rst_overflow", 32'(bus.overflow),        32'd0);
        chk("rst_uf",       32'(bus.underflow_cnt),   32'd0);
        reset = 1'b0;

        // ---------------- prefill 4 pairs, FILL->RUN one cycle later
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, i, -i, 1'b0);
            tick();
        end
        chk("pf_count", 32'(bus.count), 32'd4);
        apply(1'b0, 0, 0, 1'b0);
        chk("pf_still_fill_wd", 32'(bus.writedata_left), 32'd0);
        tick();
        chk("pf_run_wd_left",  32'(bus.writedata_left),  s24(1));
        chk("pf_run_wd_right", 32'(bus.writedata_right), s24(-1));
        chk("pf_in_ready",     32'(bus.in_ready),        32'd1);
        chk("pf_overflow",     32'(bus.overflow),        32'd0);

        // ---------------- drain 4 then starve twice
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 0, 0, 1'b1);
            chk("dr_write",    32'(bus.write),           32'd1);
            chk("dr_wd_left",  32'(bus.writedata_left),  s24(c_drain_l[k]));
            chk("dr_wd_right", 32'(bus.writedata_right), s24(-c_drain_l[k]));
            tick();
            chk("dr_uf",    32'(bus.underflow_cnt), 32'(c_drain_uf[k]));
            chk("dr_count", 32'(bus.count),         32'(c_drain_cnt[k]));
        end

        // ---------------- prefill gate: 3 pairs never drain
        do_reset();
        for (int i = 11; i <= 13; i++) begin
            apply(1'b1, i, -i, 1'b0);
            tick();
        end
        for (int p = 0; p < 5; p++) begin
            apply(1'b0, 0, 0, 1'b1);
            chk("gate_write",   32'(bus.write),          32'd1);
            chk("gate_wd_left", 32'(bus.writedata_left), 32'd0);
            tick();
            apply(1'b0, 0, 0, 1'b0);
            chk("gate_write_lo", 32'(bus.write), 32'd0);
            tick();
            chk("gate_count", 32'(bus.count),         32'd3);
            chk("gate_uf",    32'(bus.underflow_cnt), 32'd0);
        end

        // ---------------- overflow: 9 pushes into 8 slots
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            apply(1'b1, i, -i, 1'b0);
            chk("ov_in_ready", 32'(bus.in_ready), (i <= 8) ? 32'd1 : 32'd0);
            tick();
            chk("ov_flag",  32'(bus.overflow), (i == 9) ? 32'd1 : 32'd0);
            chk("ov_count", 32'(bus.count),    32'((i > 8) ? 8 : i));
        end
        // push while full alongside a pop: push is dropped
        apply(1'b1, 99, -99, 1'b1);
        chk("ov_full_ready", 32'(bus.in_ready),       32'd0);
        chk("ov_head",       32'(bus.writedata_left), s24(1));
        tick();
        chk("ov_pop_count", 32'(bus.count),    32'd7);
        chk("ov_pop_ready", 32'(bus.in_ready), 32'd1);
        chk("ov_sticky",    32'(bus.overflow), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            apply(1'b0, 0, 0, 1'b1);
            chk("ov_drain", 32'(bus.writedata_left), s24(k));
            tick();
        end
        chk("ov_empty", 32'(bus.count), 32'd0);

        // ---------------- wrap-around streaming of 20 pairs
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, i, -i, 1'b0);
            tick();
        end
        apply(1'b0, 0, 0, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            apply(1'b1, k + 4, -(k + 4), 1'b1);
            chk("wr_wd_left",  32'(bus.writedata_left),  s24(k));
            chk("wr_wd_right", 32'(bus.writedata_right), s24(-k));
            tick();
            chk("wr_count", 32'(bus.count), 32'd4);
        end
        for (int k = 17; k <= 20; k++) begin
            apply(1'b0, 0, 0, 1'b1);
            chk("wr_tail", 32'(bus.writedata_left), s24(k));
            tick();
        end
        chk("wr_count_end", 32'(bus.count),         32'd0);
        chk("wr_uf",        32'(bus.underflow_cnt), 32'd0);
        chk("wr_overflow",  32'(bus.overflow),      32'd0);

        // ---------------- push into empty FIFO during accept: no bypass
        apply(1'b1, 77, -77, 1'b1);
        chk("nb_replay", 32'(bus.writedata_left), s24(20));
        tick();
        chk("nb_count", 32'(bus.count),         32'd1);
        chk("nb_uf",    32'(bus.underflow_cnt), 32'd1);
        for (int i = 78; i <= 85; i++) begin
            apply(1'b1, i, -i, 1'b0);
            tick();
        end
        chk("nb_full",     32'(bus.count),    32'd8);
        chk("nb_overflow", 32'(bus.overflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 0, 0, 1'b1);
            chk("nb_drain", 32'(bus.writedata_left), s24(77 + k));
            tick();
        end
        chk("nb_count5", 32'(bus.count), 32'd5);

        // ---------------- mid-stream reset
        reset = 1'b1;
        apply(1'b0, 0, 0, 1'b1);
        chk("mr_write_comb", 32'(bus.write), 32'd0);
        tick();
        chk("mr_count",    32'(bus.count),           32'd0);
        chk("mr_overflow", 32'(bus.overflow),        32'd0);
        chk("mr_uf",       32'(bus.underflow_cnt),   32'd0);
        chk("mr_wd_left",  32'(bus.writedata_left),  32'd0);
        chk("mr_wd_right", 32'(bus.writedata_right), 32'd0);
        chk("mr_write",    32'(bus.write),           32'd0);
        chk("mr_in_ready", 32'(bus.in_ready),        32'd1);
        reset = 1'b0;
        apply(1'b0, 0, 0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
